// File: rtl/usb_buf_pkg.sv
// Shared defaults and types for the packet-aware USB endpoint buffer.
package usb_buf_pkg;

  localparam int USB_BUF_DATA_W = 8;
  localparam int USB_BUF_DEPTH  = 64;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic collision;
  } buf_err_t;

endpackage

// File: rtl/usb_buf_mem.sv
// DEPTH x DATA_W register array, one write port, read data taken straight from the array
// registers (the popped byte is captured into output flops by the parent). Storage is not reset.
module usb_buf_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/usb_pkt_buffer.sv
// Packet-aware endpoint buffer: RX bytes stay pending until committed, aborted packets vanish.
// Pointers rd/cm/wr carry a wrap bit so all occupancy differences are exact modulo 2*DEPTH.
module usb_pkt_buffer
  import usb_buf_pkg::*;
#(
  parameter int DATA_W = USB_BUF_DATA_W,
  parameter int DEPTH  = USB_BUF_DEPTH,
  localparam int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic              flush,
  input  logic              store_rx_packet_data,
  input  logic [DATA_W-1:0] rx_packet_data,
  input  logic              rx_commit,
  input  logic              rx_abort,
  input  logic              store_tx_data,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              get_rx_data,
  input  logic              get_tx_packet_data,
  output logic [DATA_W-1:0] rx_data,
  output logic [DATA_W-1:0] tx_packet_data,
  output logic [OCC_W-1:0]  buffer_occupancy,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow,
  output logic              collision
);

  localparam int AW = OCC_W - 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  logic [OCC_W-1:0]  rd_ptr_q, rd_ptr_d, cm_ptr_q, cm_ptr_d, wr_ptr_q, wr_ptr_d;
  logic              poison_q, poison_d;
  buf_err_t          err_q, err_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d, tx_data_q, tx_data_d;

  logic [OCC_W-1:0]  committed, pending, used, wr_next, cm_next;
  logic              pop_req, pop_ok, rx_fits, rx_drop;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  usb_buf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (mem_wdata),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (mem_rdata)
  );

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    cm_ptr_d  = cm_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    poison_d  = poison_q;
    err_d     = err_q;
    rx_data_d = rx_data_q;
    tx_data_d = tx_data_q;
    mem_we    = 1'b0;
    mem_wdata = rx_packet_data;
    rx_drop   = 1'b0;
    wr_next   = wr_ptr_q;
    cm_next   = cm_ptr_q;

    committed = cm_ptr_q - rd_ptr_q;
    pending   = wr_ptr_q - cm_ptr_q;
    used      = wr_ptr_q - rd_ptr_q;
    pop_req   = get_rx_data | get_tx_packet_data;
    pop_ok    = pop_req && (committed != '0);
    // A full buffer still takes an RX byte when a pop frees the slot this cycle.
    rx_fits   = (used != DEPTH_OCC) || pop_ok;

    if (clear || flush) begin
      rd_ptr_d  = '0;
      cm_ptr_d  = '0;
      wr_ptr_d  = '0;
      poison_d  = 1'b0;
      err_d     = '0;
      rx_data_d = '0;
      tx_data_d = '0;
    end else begin
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        if (get_rx_data)        rx_data_d = mem_rdata;
        if (get_tx_packet_data) tx_data_d = mem_rdata;
      end else if (pop_req) begin
        err_d.underflow = 1'b1;
      end

      if (store_rx_packet_data) begin
        if (store_tx_data) err_d.collision = 1'b1;
        if (!rx_abort) begin
          if (rx_fits) begin
            mem_we  = 1'b1;
            wr_next = wr_ptr_q + 1'b1;
          end else begin
            err_d.overflow = 1'b1;
            rx_drop        = 1'b1;
          end
        end
      end else if (store_tx_data) begin
        if (pending != '0) begin
          err_d.collision = 1'b1;
        end else if (used == DEPTH_OCC) begin
          err_d.overflow = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_wdata = tx_data;
          wr_next   = wr_ptr_q + 1'b1;
          cm_next   = cm_ptr_q + 1'b1;
        end
      end

      // A byte dropped in the commit cycle poisons the packet just as an earlier drop does.
      if (rx_abort || (rx_commit && (poison_q || rx_drop))) begin
        cm_ptr_d = cm_next;
        wr_ptr_d = cm_next;
        poison_d = 1'b0;
      end else if (rx_commit) begin
        cm_ptr_d = wr_next;
        wr_ptr_d = wr_next;
        poison_d = 1'b0;
      end else begin
        cm_ptr_d = cm_next;
        wr_ptr_d = wr_next;
        poison_d = poison_q | rx_drop;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr_q  <= '0;
      cm_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      poison_q  <= 1'b0;
      err_q     <= '0;
      rx_data_q <= '0;
      tx_data_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      cm_ptr_q  <= cm_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      poison_q  <= poison_d;
      err_q     <= err_d;
      rx_data_q <= rx_data_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign rx_data          = rx_data_q;
  assign tx_packet_data   = tx_data_q;
  assign buffer_occupancy = cm_ptr_q - rd_ptr_q;
  assign full             = ((wr_ptr_q - rd_ptr_q) == DEPTH_OCC);
  assign empty            = (cm_ptr_q == rd_ptr_q);
  assign overflow         = err_q.overflow;
  assign underflow        = err_q.underflow;
  assign collision        = err_q.collision;

endmodule

// File: tb/tb_usb_pkt_buffer.sv
// Directed scenarios plus random traffic against a queue-based model of committed/pending bytes.
module tb_usb_pkt_buffer;
  localparam int DW = 8;
  localparam int D  = 8;
  localparam int OW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          clear = 0, flush = 0, store_rx = 0, commit = 0, abort = 0, store_tx = 0;
  logic          get_rx = 0, get_tx = 0;
  logic [DW-1:0] rx_b = '0, tx_b = '0;
  logic [DW-1:0] rx_data, tx_packet_data;
  logic [OW-1:0] occ;
  logic          full, empty, overflow, underflow, collision;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] cq[$];
  logic [DW-1:0] pq[$];
  logic [DW-1:0] m_rx, m_tx;
  bit            m_poison, m_ovf, m_unf, m_col;

  usb_pkt_buffer #(.DATA_W(DW), .DEPTH(D)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear), .flush(flush),
    .store_rx_packet_data(store_rx), .rx_packet_data(rx_b),
    .rx_commit(commit), .rx_abort(abort),
    .store_tx_data(store_tx), .tx_data(tx_b),
    .get_rx_data(get_rx), .get_tx_packet_data(get_tx),
    .rx_data(rx_data), .tx_packet_data(tx_packet_data),
    .buffer_occupancy(occ), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow), .collision(collision)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cq.delete(); pq.delete();
    m_rx = '0; m_tx = '0;
    m_poison = 0; m_ovf = 0; m_unf = 0; m_col = 0;
  endtask

  task automatic model_step();
    int csz, used;
    bit popped, drop;
    logic [DW-1:0] b;
    drop = 0; popped = 0;
    if (clear || flush) begin
      model_reset();
      return;
    end
    csz  = cq.size();
    used = csz + pq.size();
    if (get_rx || get_tx) begin
      if (csz > 0) begin
        b = cq.pop_front();
        popped = 1;
        if (get_rx) m_rx = b;
        if (get_tx) m_tx = b;
      end else m_unf = 1;
    end
    if (store_rx) begin
      if (store_tx) m_col = 1;
      if (!abort) begin
        if (used < D || popped) pq.push_back(rx_b);
        else begin m_ovf = 1; drop = 1; end
      end
    end else if (store_tx) begin
      if (pq.size() != 0) m_col = 1;
      else if (used == D) m_ovf = 1;
      else cq.push_back(tx_b);
    end
    if (abort || (commit && (m_poison || drop))) begin
      pq.delete(); m_poison = 0;
    end else if (commit) begin
      foreach (pq[i]) cq.push_back(pq[i]);
      pq.delete(); m_poison = 0;
    end else if (drop) m_poison = 1;
  endtask

  task automatic check_all();
    chk("occupancy", 32'(occ), 32'(cq.size()));
    chk("full", 32'(full), 32'((cq.size() + pq.size()) == D));
    chk("empty", 32'(empty), 32'(cq.size() == 0));
    chk("rx_data", 32'(rx_data), 32'(m_rx));
    chk("tx_packet_data", 32'(tx_packet_data), 32'(m_tx));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("collision", 32'(collision), 32'(m_col));
  endtask

  // One clock cycle with the currently driven inputs; strobes drop afterwards.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
    {clear, flush, store_rx, commit, abort, store_tx, get_rx, get_tx} = '0;
  endtask

  task automatic rx(input logic [DW-1:0] b);
    store_rx = 1; rx_b = b; tick();
  endtask

  task automatic tx(input logic [DW-1:0] b);
    store_tx = 1; tx_b = b; tick();
  endtask

  task automatic pop_rx();
    get_rx = 1; tick();
  endtask

  task automatic do_clear();
    clear = 1; tick();
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset_empty", 32'(empty), 32'd1);
    check_all();
    n_rst = 1'b1;

    // Commit path
    rx(8'hA5); rx(8'h3C); rx(8'h7E);
    chk("occ_before_commit", 32'(occ), 32'd0);
    commit = 1; tick();
    chk("occ_after_commit", 32'(occ), 32'd3);
    pop_rx(); chk("pop1", 32'(rx_data), 32'hA5);
    pop_rx(); chk("pop2", 32'(rx_data), 32'h3C);
    pop_rx(); chk("pop3", 32'(rx_data), 32'h7E);
    chk("empty_end", 32'(empty), 32'd1);

    // Abort path
    do_clear();
    for (int i = 0; i < 5; i++) rx(8'(8'h40 + i));
    abort = 1; tick();
    pop_rx();
    chk("abort_occ", 32'(occ), 32'd0);
    chk("abort_underflow", 32'(underflow), 32'd1);
    chk("abort_rx_data", 32'(rx_data), 32'd0);

    // Overflow with poison
    do_clear();
    for (int i = 0; i < 8; i++) rx(8'(8'h80 + i));
    chk("full_at_9th", 32'(full), 32'd1);
    rx(8'h99);
    chk("ovf_flag", 32'(overflow), 32'd1);
    commit = 1; tick();
    chk("poison_occ", 32'(occ), 32'd0);

    // Wrap-around, TX writes popped from both sides
    do_clear();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 6; i++) tx(8'(p * 16 + i + 1));
      chk("wrap_occ6", 32'(occ), 32'd6);
      for (int i = 0; i < 6; i++) begin
        if (i[0]) get_tx = 1; else get_rx = 1;
        tick();
        chk("wrap_byte", 32'(i[0] ? tx_packet_data : rx_data), 32'(p * 16 + i + 1));
      end
      chk("wrap_occ0", 32'(occ), 32'd0);
    end

    // Collision
    do_clear();
    rx(8'h21); rx(8'h22);
    tx(8'h11);
    chk("collision", 32'(collision), 32'd1);
    commit = 1; tick();
    pop_rx(); pop_rx(); pop_rx();
    chk("no_0x11", 32'(rx_data != 8'h11), 32'd1);

    // Flush dominance
    do_clear();
    tx(8'h55); tx(8'h66); rx(8'h77);
    flush = 1; commit = 1; get_rx = 1; tick();
    chk("flush_occ", 32'(occ), 32'd0);
    chk("flush_rx_data", 32'(rx_data), 32'd0);
    chk("flush_underflow", 32'(underflow), 32'd0);

    // Reset mid-packet discards pending bytes
    tx(8'h12); rx(8'h34); rx(8'h56);
    n_rst = 1'b0;
    model_reset();
    #2;
    check_all();
    #2;
    n_rst = 1'b1;

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      clear    = ($urandom_range(0, 99) == 0);
      flush    = ($urandom_range(0, 99) == 0);
      store_rx = ($urandom_range(0, 1) == 0);
      rx_b     = 8'($urandom);
      store_tx = ($urandom_range(0, 3) == 0);
      tx_b     = 8'($urandom);
      commit   = ($urandom_range(0, 6) == 0);
      abort    = ($urandom_range(0, 15) == 0);
      get_rx   = ($urandom_range(0, 2) == 0);
      get_tx   = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
